// File: rtl/matmlt.sv
// matmlt: serial GF(2) matrix-vector multiplier, mlt_out = A * x.
// Matrix A (M rows of N bits) is never stored. Row 0 is SEED, and each next row
// is produced by an xorshift step. One row is evaluated per clock while BUSY.
// Handshake: req_valid/req_ready accepts x_in. res_valid/res_ready hands the
// result back. req_busy flags a computation in progress.
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   x_in [N-1:0]    : input vector, latched on request acceptance
//   req_valid/ready : request handshake
//   req_busy        : computation in progress
//   mlt_out [M-1:0] : result vector
//   res_valid/ready : result handshake
// Build option: MATMLT_OUT_HOLD_EN keeps the previous result on mlt_out until
// a new one is complete. Without it, mlt_out is the working accumulator.
module matmlt #(
   parameter int unsigned  M    = 256,
   parameter int unsigned  N    = 128,
   parameter logic [N-1:0] SEED = N'(1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] x_in,
   output logic [M-1:0] mlt_out,
   input  logic         req_valid,
   output logic         req_ready,
   output logic         req_busy,
   output logic         res_valid,
   input  logic         res_ready
);

   localparam int unsigned IW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t          state, state_n;
   logic            accept;
   logic [N-1:0]    x_q;
   logic [N-1:0]    row;
   logic [IW-1:0]   idx;
   logic            flush;
   logic [M-1:0]    acc;

   function automatic logic [N-1:0] next_row(input logic [N-1:0] r);
      logic [N-1:0] t, u;
      t = r ^ (r << 23);
      u = t ^ (t >> 17);
      return u ^ (u << 26);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // flush marks the extra BUSY cycle after the last row, so DONE is entered
   // M+1 edges after acceptance.
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      case (state)
         IDLE: if (req_valid && req_ready) begin
            accept  = 1'b1;
            state_n = BUSY;
         end
         BUSY: if (flush) state_n = DONE;
         DONE: if (res_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Handshake outputs are registered from next state. req_ready stays low
   // through reset and rises on the first edge after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready <= 1'b0;
         req_busy  <= 1'b0;
         res_valid <= 1'b0;
      end else begin
         req_ready <= (state_n == IDLE);
         req_busy  <= (state_n == BUSY);
         res_valid <= (state_n == DONE);
      end
   end

`ifdef MATMLT_OUT_HOLD_EN
   logic [M-1:0] out_q;
   assign mlt_out = out_q;
`else
   assign mlt_out = acc;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q   <= '0;
         row   <= '0;
         idx   <= '0;
         flush <= 1'b0;
         acc   <= '0;
`ifdef MATMLT_OUT_HOLD_EN
         out_q <= '0;
`endif
      end else if (accept) begin
         x_q   <= x_in;
         row   <= SEED;
         idx   <= '0;
         flush <= 1'b0;
         acc   <= '0;
      end else if (state == BUSY) begin
         if (!flush) begin
            acc[idx] <= ^(row & x_q);
            row      <= next_row(row);
            if (idx == IW'(M - 1)) flush <= 1'b1;
            else                   idx   <= idx + 1'b1;
         end else begin
            flush <= 1'b0;
`ifdef MATMLT_OUT_HOLD_EN
            out_q <= acc;
`endif
         end
      end
   end

endmodule

// File: tb/tb_matmlt.sv
// Self-checking bench for matmlt. It uses directed steps with random vectors.
// Each result is checked against a plain-arithmetic model of A*x over GF(2).
module tb_matmlt;

   localparam int unsigned M = 256;
   localparam int unsigned N = 128;
   localparam logic [N-1:0] SEED = N'(1);

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] x_in = '0;
   logic [M-1:0] mlt_out;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic         req_busy;
   logic         res_valid;
   logic         res_ready = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;
   logic [M-1:0] prev_res = '0;

   matmlt #(.M(M), .N(N), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .x_in(x_in), .mlt_out(mlt_out),
      .req_valid(req_valid), .req_ready(req_ready), .req_busy(req_busy),
      .res_valid(res_valid), .res_ready(res_ready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: walk the row recurrence and take the parity of row & x.
   function automatic logic [M-1:0] model(input logic [N-1:0] x);
      logic [N-1:0] r, t, u;
      logic [M-1:0] res;
      r = SEED;
      res = '0;
      for (int i = 0; i < int'(M); i++) begin
         res[i] = ^(r & x);
         t = r ^ (r << 23);
         u = t ^ (t >> 17);
         r = u ^ (u << 26);
      end
      return res;
   endfunction

   // Drive a request and return #1 after the acceptance edge.
   task automatic start_req(input logic [N-1:0] x);
      int k;
      @(negedge clk);
      req_valid = 1'b1;
      x_in = x;
      k = 0;
      while (req_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("ready_before_req", M'(req_ready), M'(1));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      x_in = N'($urandom);
      check("busy_after_accept", M'(req_busy), M'(1));
      check("ready_after_accept", M'(req_ready), M'(0));
`ifdef MATMLT_OUT_HOLD_EN
      check("hold_at_accept", mlt_out, prev_res);
`else
      check("clear_at_accept", mlt_out, '0);
`endif
   endtask

   // Count edges to res_valid, then check the latency and the result.
   task automatic wait_result(input string tag, input logic [M-1:0] exp);
      int lat;
      lat = 0;
      while (lat < 2000) begin
         @(posedge clk);
         #1;
         lat++;
         // A res_ready pulse while BUSY must be ignored.
         res_ready = (lat >= 10 && lat < 20);
         if (lat == 100) begin
`ifdef MATMLT_OUT_HOLD_EN
            check("hold_during_busy", mlt_out, prev_res);
`else
            check("busy_mid", M'(req_busy), M'(1));
`endif
         end
         if (res_valid === 1'b1) break;
      end
      res_ready = 1'b0;
      check({tag, "_latency"}, M'(lat), M'(M + 1));
      check({tag, "_result"}, mlt_out, exp);
      check({tag, "_busy_low"}, M'(req_busy), M'(0));
      prev_res = exp;
   endtask

   task automatic release_res;
      @(negedge clk);
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release_valid_low", M'(res_valid), M'(0));
      check("release_ready_high", M'(req_ready), M'(1));
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   initial begin
      logic [N-1:0] xc;
      logic [N-1:0] xr;
      logic [M-1:0] e;
      bit seen;

      // Reset values are applied asynchronously.
      #1;
      check("rst_ready", M'(req_ready), M'(0));
      check("rst_busy", M'(req_busy), M'(0));
      check("rst_valid", M'(res_valid), M'(0));
      check("rst_out", mlt_out, '0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_rst", M'(req_ready), M'(1));

      // Zero vector gives a zero result.
      start_req('0);
      wait_result("zero", '0);
      release_res();

      // x = 1 selects bit 0 of every row.
      start_req(N'(1));
      e = model(N'(1));
      wait_result("unit", e);
      check("unit_bit0", M'(mlt_out[0]), M'(1));
      check("unit_bit1", M'(mlt_out[1]), M'(1));
      release_res();

      // The same vector twice must give the same result.
      xc = 128'h139871fcaa59a6eab6afb399292871e9;
      e = model(xc);
      for (int rep = 0; rep < 2; rep++) begin
         start_req(xc);
         wait_result("fixed", e);
         release_res();
      end

      // Random vectors.
      for (int k = 0; k < 3; k++) begin
         xr = {$urandom, $urandom, $urandom, $urandom};
         start_req(xr);
         wait_result("rand", model(xr));
         release_res();
      end

      // DONE holds while res_ready is low, whatever the request side does.
      xr = {$urandom, $urandom, $urandom, $urandom};
      e = model(xr);
      start_req(xr);
      wait_result("stall", e);
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         x_in = {$urandom, $urandom, $urandom, $urandom};
         req_valid = 1'($urandom);
         @(posedge clk);
         #1;
         check("stall_valid", M'(res_valid), M'(1));
         check("stall_out", mlt_out, e);
         check("stall_ready", M'(req_ready), M'(0));
      end
      @(negedge clk);
      req_valid = 1'b0;
      release_res();

      // Reset part-way through BUSY aborts the computation.
      start_req(xc);
      repeat (100) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_ready", M'(req_ready), M'(0));
      check("abort_busy", M'(req_busy), M'(0));
      check("abort_valid", M'(res_valid), M'(0));
      check("abort_out", mlt_out, '0);
      prev_res = '0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("abort_ready_back", M'(req_ready), M'(1));
      seen = 1'b0;
      repeat (300) begin
         @(posedge clk);
         #1;
         if (res_valid !== 1'b0) seen = 1'b1;
      end
      check("abort_no_result", M'(seen), M'(0));
      start_req(xc);
      wait_result("after_abort", model(xc));

      // A req_valid held through release starts the next run on the first IDLE cycle.
      xr = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      req_valid = 1'b1;
      x_in = xr;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      check("held_idle_ready", M'(req_ready), M'(1));
      @(negedge clk);
      res_ready = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("held_accept_busy", M'(req_busy), M'(1));
      wait_result("held", model(xr));
      release_res();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
